// File: rtl/osc_pkg.sv
// Shared types and default constants for the oscillator frequency monitor.
`timescale 1ns/1ps
package osc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } osc_state_e;

  localparam int RCOSC_HZ        = 160_000_000;
  // 1 ms gate at the RC oscillator rate, so COUNT reads directly in kHz
  localparam int DEF_GATE_CYCLES = RCOSC_HZ / 1000;
  localparam int DEF_CNT_W       = 18;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge
// strobe. Usable for any slow asynchronous level or clock input.
`timescale 1ns/1ps
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_o
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_edge_det: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  // shift the input through the synchronizer, then one extra delay stage
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  // synchronizer and delay registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/osc_freq_mon.sv
// Frequency monitor: counts synchronized rising edges of MEAS_IN over a gate
// window of GATE_CYCLES clocks and reports the count with range/loss flags.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | counters held at 0, waiting for EN
// MEASURE | gate window running; terminal cycle publishes result, restarts
`timescale 1ns/1ps
module osc_freq_mon
  import osc_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LO_LIMIT    = 24000,
  parameter int HI_LIMIT    = 26000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             MEAS_IN,
  output logic [CNT_W-1:0] COUNT,
  output logic             VALID,
  output logic             FREQ_OK,
  output logic             LOST,
  output logic             SAT
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  LO_LIM    = CNT_W'(LO_LIMIT);
  localparam logic [CNT_W-1:0]  HI_LIM    = CNT_W'(HI_LIMIT);

  if ((LO_LIMIT > HI_LIMIT) || (HI_LIMIT >= (1 << CNT_W))) begin : g_bad_limits
    $error("osc_freq_mon: need LO_LIMIT <= HI_LIMIT < 2**CNT_W");
  end

  osc_state_e        state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              freq_ok_q, freq_ok_d;
  logic              lost_q, lost_d;
  logic              sat_q, sat_d;
  logic              meas_edge;
  logic [CNT_W-1:0]  result;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (CLK),
    .rst     (RST),
    .async_in(MEAS_IN),
    .edge_o  (meas_edge)
  );

  // edge count including this cycle's strobe, sticking at full scale
  assign result = (edge_cnt_q == CNT_MAX) ? CNT_MAX
                                          : edge_cnt_q + CNT_W'(meas_edge);

  // next state, counters and result registers
  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    edge_cnt_d = edge_cnt_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    freq_ok_d  = freq_ok_q;
    lost_d     = lost_q;
    sat_d      = sat_q;
    case (state_q)
      IDLE: begin
        gate_d     = '0;
        edge_cnt_d = '0;
        if (EN) state_d = MEASURE;
      end
      MEASURE: begin
        if (gate_q == GATE_LAST) begin
          // a window that ends as EN falls still completes and reports
          count_d    = result;
          sat_d      = (result == CNT_MAX);
          lost_d     = (result == '0);
          freq_ok_d  = (result != CNT_MAX) && (result >= LO_LIM) && (result <= HI_LIM);
          valid_d    = 1'b1;
          gate_d     = '0;
          edge_cnt_d = '0;
          state_d    = EN ? MEASURE : IDLE;
        end else if (!EN) begin
          gate_d     = '0;
          edge_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          gate_d     = gate_q + GATE_W'(1);
          edge_cnt_d = result;
        end
      end
      default: begin
        gate_d     = '0;
        edge_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // state, counter and result registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      freq_ok_q  <= 1'b0;
      lost_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      edge_cnt_q <= edge_cnt_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      freq_ok_q  <= freq_ok_d;
      lost_q     <= lost_d;
      sat_q      <= sat_d;
    end
  end

  assign COUNT   = count_q;
  assign VALID   = valid_q;
  assign FREQ_OK = freq_ok_q;
  assign LOST    = lost_q;
  assign SAT     = sat_q;

endmodule

// File: tb/tb_osc_freq_mon.sv
// Directed bench for osc_freq_mon: a 8-bit instance for range/loss/enable
// behaviour and a 4-bit instance for saturation and mid-window reset.
`timescale 1ns/1ps
module tb_osc_freq_mon;

  logic       clk = 1'b0;
  logic       rst, en, rst_s, en_s;
  logic       meas_in = 1'b0;
  logic [7:0] count;
  logic       valid, freq_ok, lost, sat;
  logic [3:0] count_s;
  logic       valid_s, freq_ok_s, lost_s, sat_s;

  int n_tests = 0;
  int n_fail  = 0;
  int meas_period = 4;
  int meas_ph = 0;

  osc_freq_mon #(
    .GATE_CYCLES(100), .CNT_W(8), .LO_LIMIT(20), .HI_LIMIT(30), .SYNC_STAGES(2)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en), .MEAS_IN(meas_in),
    .COUNT(count), .VALID(valid), .FREQ_OK(freq_ok), .LOST(lost), .SAT(sat)
  );

  osc_freq_mon #(
    .GATE_CYCLES(100), .CNT_W(4), .LO_LIMIT(10), .HI_LIMIT(14), .SYNC_STAGES(2)
  ) dut_s (
    .CLK(clk), .RST(rst_s), .EN(en_s), .MEAS_IN(meas_in),
    .COUNT(count_s), .VALID(valid_s), .FREQ_OK(freq_ok_s), .LOST(lost_s), .SAT(sat_s)
  );

  initial forever #3.125 clk = ~clk;

  // test clock: period meas_period CLK cycles, 0 means stuck low
  initial forever begin
    @(posedge clk);
    #2;
    if (meas_period == 0) begin
      meas_ph = 0;
      meas_in = 1'b0;
    end else begin
      meas_ph = (meas_ph + 1) % meas_period;
      meas_in = (meas_ph < meas_period / 2);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // cycles until VALID (or VALID of the 4-bit instance) is seen, -1 on timeout
  task automatic wait_valid(input bit sat_inst, output int n);
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if ((sat_inst ? valid_s : valid) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int  n;
    bit  v_seen;

    rst = 1'b1; en = 1'b1; rst_s = 1'b1; en_s = 1'b1;

    // reset held 5 cycles with MEAS_IN toggling and EN high
    v_seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (valid === 1'b1) v_seen = 1'b1;
    end
    check("rst_no_valid", 32'(v_seen), 0);
    check("rst_count",   32'(count),   0);
    check("rst_freq_ok", 32'(freq_ok), 0);
    check("rst_lost",    32'(lost),    0);
    check("rst_sat",     32'(sat),     0);
    check("rst_count_s", 32'(count_s), 0);

    // first VALID 101 cycles after EN is sampled in IDLE
    rst = 1'b0;
    wait_valid(1'b0, n);
    check("first_valid_latency", 32'(n), 101);
    @(posedge clk); #1;
    check("valid_single_cycle", 32'(valid), 0);
    wait_valid(1'b0, n);
    check("valid_repeat_100", 32'(n), 99);

    // period 4 -> 25 edges
    check("p4_count",   32'(count),   25);
    check("p4_freq_ok", 32'(freq_ok), 1);
    check("p4_lost",    32'(lost),    0);
    check("p4_sat",     32'(sat),     0);

    // period 5 -> 20 edges, lower boundary still in range
    meas_period = 5;
    wait_valid(1'b0, n);
    wait_valid(1'b0, n);
    check("p5_period", 32'(n), 100);
    check("p5_count",   32'(count),   20);
    check("p5_freq_ok", 32'(freq_ok), 1);

    // period 10 -> 10 edges, below range
    meas_period = 10;
    wait_valid(1'b0, n);
    wait_valid(1'b0, n);
    check("p10_count",   32'(count),   10);
    check("p10_freq_ok", 32'(freq_ok), 0);
    check("p10_lost",    32'(lost),    0);

    // stuck low -> loss of clock
    meas_period = 0;
    wait_valid(1'b0, n);
    wait_valid(1'b0, n);
    check("stuck_count",   32'(count),   0);
    check("stuck_lost",    32'(lost),    1);
    check("stuck_freq_ok", 32'(freq_ok), 0);

    // restart at period 4, second window is fully clocked
    meas_period = 4;
    wait_valid(1'b0, n);
    wait_valid(1'b0, n);
    check("restart_count",   32'(count),   25);
    check("restart_lost",    32'(lost),    0);
    check("restart_freq_ok", 32'(freq_ok), 1);

    // EN dropped 50 cycles into a window: no VALID, results hold
    repeat (49) @(posedge clk);
    #1;
    en = 1'b0;
    v_seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (valid === 1'b1) v_seen = 1'b1;
    end
    check("en_drop_no_valid", 32'(v_seen),  0);
    check("en_drop_count",    32'(count),   25);
    check("en_drop_freq_ok",  32'(freq_ok), 1);
    en = 1'b1;
    wait_valid(1'b0, n);
    check("en_reassert_latency", 32'(n), 101);
    check("en_reassert_count", 32'(count), 25);

    // 4-bit instance: 25 edges saturate at 15
    rst_s = 1'b0;
    wait_valid(1'b1, n);
    check("sat_latency",   32'(n),         101);
    check("sat_count",     32'(count_s),   15);
    check("sat_flag",      32'(sat_s),     1);
    check("sat_freq_ok",   32'(freq_ok_s), 0);
    check("sat_lost",      32'(lost_s),    0);

    // reset 60 cycles into the next window: outputs clear, no VALID
    repeat (59) @(posedge clk);
    #1;
    rst_s = 1'b1;
    @(posedge clk); #1;
    check("midrst_count", 32'(count_s), 0);
    check("midrst_sat",   32'(sat_s),   0);
    v_seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (valid_s === 1'b1) v_seen = 1'b1;
    end
    check("midrst_no_valid", 32'(v_seen), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
